// File: rtl/alu_cmp_pkg.sv
// Shared types for the ALU compare unit.
// Opcode encoding of the relational / min-max operations.
package alu_cmp_pkg;

    localparam int CMP_OP_W = 3;

    typedef enum logic [CMP_OP_W-1:0] {
        OP_GT  = 3'd0,
        OP_LT  = 3'd1,
        OP_EQ  = 3'd2,
        OP_NE  = 3'd3,
        OP_GE  = 3'd4,
        OP_LE  = 3'd5,
        OP_MIN = 3'd6,
        OP_MAX = 3'd7
    } cmp_op_e;

endpackage

// File: rtl/cmp_core.sv
// Combinational magnitude compare, signed or unsigned.
// Signed mode flips both MSBs so one unsigned compare serves both modes.
module cmp_core
    import alu_cmp_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    logic [WIDTH-1:0] ka;
    logic [WIDTH-1:0] kb;

    // Offset-binary view: most-negative value maps to zero, no negation needed
    assign ka = {a[WIDTH-1] ^ is_signed, a[WIDTH-2:0]};
    assign kb = {b[WIDTH-1] ^ is_signed, b[WIDTH-2:0]};

    assign lt = (ka < kb);
    assign eq = (ka == kb);
    assign gt = (ka > kb);

endmodule

// File: rtl/cmp_pipe_unit.sv
// Two-stage valid/ready compare pipeline: S1 holds operands, S2 holds
// flags and the selected result. Full backpressure, one beat per cycle.
module cmp_pipe_unit
    import alu_cmp_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    input  logic [CMP_OP_W-1:0] in_op,
    input  logic                in_signed,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_result,
    output logic                out_lt,
    output logic                out_eq,
    output logic                out_gt
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    cmp_op_e          s1_op;
    logic             s1_sgn;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    logic             s2_lt;
    logic             s2_eq;
    logic             s2_gt;

    logic             s1_load;
    logic             s2_load;
    logic             c_lt;
    logic             c_eq;
    logic             c_gt;
    logic [WIDTH-1:0] res_n;

    assign s2_load  = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    cmp_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a        (s1_a),
        .b        (s1_b),
        .is_signed(s1_sgn),
        .lt       (c_lt),
        .eq       (c_eq),
        .gt       (c_gt)
    );

    always_comb begin
        res_n = '0;
        unique case (s1_op)
            OP_GT:   res_n[0] = c_gt;
            OP_LT:   res_n[0] = c_lt;
            OP_EQ:   res_n[0] = c_eq;
            OP_NE:   res_n[0] = !c_eq;
            OP_GE:   res_n[0] = c_gt || c_eq;
            OP_LE:   res_n[0] = c_lt || c_eq;
            OP_MIN:  res_n = (c_lt || c_eq) ? s1_a : s1_b;
            OP_MAX:  res_n = (c_gt || c_eq) ? s1_a : s1_b;
            default: res_n = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_op     <= OP_GT;
            s1_sgn    <= 1'b0;
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_lt     <= 1'b0;
            s2_eq     <= 1'b0;
            s2_gt     <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_a   <= in_a;
                    s1_b   <= in_b;
                    s1_op  <= cmp_op_e'(in_op);
                    s1_sgn <= in_signed;
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_result <= res_n;
                    s2_lt     <= c_lt;
                    s2_eq     <= c_eq;
                    s2_gt     <= c_gt;
                end
            end
        end
    end

    assign out_valid  = s2_valid;
    assign out_result = s2_result;
    assign out_lt     = s2_lt;
    assign out_eq     = s2_eq;
    assign out_gt     = s2_gt;

endmodule

// File: tb/tb_cmp_pipe_unit.sv
// Bench for cmp_pipe_unit: directed cases plus random traffic on a
// 6-bit and a 16-bit instance, checked against an integer reference.
module tb_cmp_pipe_unit;

    typedef struct {
        logic [15:0] res;
        logic        lt;
        logic        eq;
        logic        gt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v6, r6, ov6, or6, sg6, lt6, eq6, gt6;
    logic [5:0]  a6, b6, res6;
    logic [2:0]  op6;
    logic        v16, r16, ov16, or16, sg16, lt16, eq16, gt16;
    logic [15:0] a16, b16, res16;
    logic [2:0]  op16;

    exp_t q6[$];
    exp_t q16[$];
    exp_t cur6, cur16;
    int   total = 0;
    int   bad = 0;
    int   cnt = 0;
    bit   fired6 = 0;
    bit   fired16 = 0;
    bit   hold6 = 0;
    logic [8:0] hval;

    cmp_pipe_unit #(.WIDTH(6)) dut6 (
        .clk(clk), .rst(rst),
        .in_valid(v6), .in_ready(r6), .in_a(a6), .in_b(b6),
        .in_op(op6), .in_signed(sg6),
        .out_valid(ov6), .out_ready(or6), .out_result(res6),
        .out_lt(lt6), .out_eq(eq6), .out_gt(gt6)
    );

    cmp_pipe_unit #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(v16), .in_ready(r16), .in_a(a16), .in_b(b16),
        .in_op(op16), .in_signed(sg16),
        .out_valid(ov16), .out_ready(or16), .out_result(res16),
        .out_lt(lt16), .out_eq(eq16), .out_gt(gt16)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: interpret operands as integers, then apply the op rules
    function automatic exp_t model(logic [15:0] a, logic [15:0] b,
                                   logic [2:0] op, bit sg, int w);
        exp_t e;
        longint sa, sb, half;
        half = longint'(1) << (w - 1);
        sa = longint'(a);
        sb = longint'(b);
        if (sg && sa >= half) sa = sa - 2 * half;
        if (sg && sb >= half) sb = sb - 2 * half;
        e.lt = (sa < sb);
        e.eq = (sa == sb);
        e.gt = (sa > sb);
        case (op)
            3'd0: e.res = 16'(e.gt);
            3'd1: e.res = 16'(e.lt);
            3'd2: e.res = 16'(e.eq);
            3'd3: e.res = 16'(!e.eq);
            3'd4: e.res = 16'(sa >= sb);
            3'd5: e.res = 16'(sa <= sb);
            3'd6: e.res = (sa <= sb) ? a : b;
            default: e.res = (sa >= sb) ? a : b;
        endcase
        return e;
    endfunction

    task automatic cyc();
        exp_t e;
        #2;
        if (rst) begin
            q6.delete();
            q16.delete();
            hold6 = 0;
            fired6 = 0;
            fired16 = 0;
        end else begin
            if (hold6) begin
                chk("hold_valid", 32'(ov6), 32'd1);
                chk("hold_beat", 32'({lt6, eq6, gt6, res6}), 32'(hval));
            end
            if (ov6)
                chk("onehot6", 32'(int'(lt6) + int'(eq6) + int'(gt6)), 32'd1);
            if (ov16)
                chk("onehot16", 32'(int'(lt16) + int'(eq16) + int'(gt16)), 32'd1);
            if (ov6 && or6) begin
                chk("queue6", 32'(q6.size() != 0), 32'd1);
                if (q6.size() != 0) begin
                    e = q6.pop_front();
                    chk("res6", 32'(res6), 32'(e.res));
                    chk("flags6", 32'({lt6, eq6, gt6}), 32'({e.lt, e.eq, e.gt}));
                end
            end
            if (ov16 && or16) begin
                chk("queue16", 32'(q16.size() != 0), 32'd1);
                if (q16.size() != 0) begin
                    e = q16.pop_front();
                    chk("res16", 32'(res16), 32'(e.res));
                    chk("flags16", 32'({lt16, eq16, gt16}), 32'({e.lt, e.eq, e.gt}));
                end
            end
            hold6 = ov6 && !or6;
            hval = {lt6, eq6, gt6, res6};
            fired6 = v6 && r6;
            fired16 = v16 && r16;
            if (fired6) q6.push_back(cur6);
            if (fired16) q16.push_back(cur16);
        end
        cnt++;
        @(negedge clk);
    endtask

    task automatic send6(logic [5:0] a, logic [5:0] b, logic [2:0] op,
                         bit sg, logic [15:0] res, logic lt, logic eq, logic gt);
        a6 = a;
        b6 = b;
        op6 = op;
        sg6 = sg;
        v6 = 1'b1;
        cur6 = '{res, lt, eq, gt};
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (fired6) break;
        end
        chk("send_accept", 32'(fired6), 32'd1);
        v6 = 1'b0;
    endtask

    task automatic send6m(logic [5:0] a, logic [5:0] b, logic [2:0] op, bit sg);
        exp_t e;
        e = model(16'(a), 16'(b), op, sg, 6);
        send6(a, b, op, sg, e.res, e.lt, e.eq, e.gt);
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && (q6.size() != 0 || q16.size() != 0); k++)
            cyc();
        chk("drain6", 32'(q6.size()), 32'd0);
        chk("drain16", 32'(q16.size()), 32'd0);
    endtask

    initial begin
        int sw[8];
        int idx;
        int fire_at;
        int lat;
        sw = '{0, 1, 0, 1, 0, 1, 61, 2};

        rst = 1'b1;
        v6 = 1'b1; a6 = 6'd9; b6 = 6'd3; op6 = 3'd7; sg6 = 1'b0; or6 = 1'b1;
        v16 = 1'b0; a16 = '0; b16 = '0; op16 = '0; sg16 = 1'b0; or16 = 1'b1;
        cur6 = '{16'd0, 1'b0, 1'b0, 1'b0};
        cur16 = cur6;
        repeat (3) cyc();
        chk("rst_valid", 32'(ov6), 32'd0);
        chk("rst_result", 32'(res6), 32'd0);
        chk("rst_flags", 32'({lt6, eq6, gt6}), 32'd0);
        rst = 1'b0;
        v6 = 1'b0;
        #1;
        chk("rst_ready", 32'(r6), 32'd1);

        send6(6'b100000, 6'b011111, 3'd0, 1'b1, 16'd0, 1'b1, 1'b0, 1'b0);
        send6(6'b011111, 6'b100000, 3'd0, 1'b1, 16'd1, 1'b0, 1'b0, 1'b1);
        send6(6'b100000, 6'b100000, 3'd0, 1'b1, 16'd0, 1'b0, 1'b1, 1'b0);
        send6(6'b100000, 6'b011111, 3'd0, 1'b0, 16'd1, 1'b0, 1'b0, 1'b1);
        send6(6'b100000, 6'b011111, 3'd7, 1'b0, 16'd32, 1'b0, 1'b0, 1'b1);
        send6(6'd5, 6'd5, 3'd6, 1'b0, 16'd5, 1'b0, 1'b1, 1'b0);
        send6(6'd5, 6'd5, 3'd7, 1'b0, 16'd5, 1'b0, 1'b1, 1'b0);
        for (int op = 0; op < 8; op++)
            send6(6'd61, 6'd2, 3'(op), 1'b1, 16'(sw[op]), 1'b1, 1'b0, 1'b0);
        drain();

        idx = 0;
        for (int i = 0; i < 40 && idx < 8; i++) begin
            if (!v6 || fired6) begin
                a6 = 6'($urandom);
                b6 = 6'($urandom);
                op6 = 3'($urandom);
                sg6 = 1'($urandom);
                cur6 = model(16'(a6), 16'(b6), op6, sg6, 6);
            end
            v6 = 1'b1;
            or6 = !(i >= 3 && i <= 5);
            #1;
            if (i >= 2 && i <= 5)
                chk("bp_ready", 32'(r6), (i >= 3) ? 32'd0 : 32'd1);
            cyc();
            if (fired6) idx++;
        end
        chk("bp_sent", 32'(idx), 32'd8);
        v6 = 1'b0;
        or6 = 1'b1;
        drain();

        or6 = 1'b0;
        send6m(6'd12, 6'd40, 3'd1, 1'b1);
        send6m(6'd33, 6'd7, 3'd6, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        or6 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("flush_valid", 32'(ov6), 32'd0);
            cyc();
        end
        send6m(6'd50, 6'd50, 3'd4, 1'b1);
        fire_at = cnt - 1;
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            if (ov6) begin
                lat = cnt - fire_at;
                break;
            end
            cyc();
        end
        chk("latency", 32'(lat), 32'd2);
        drain();

        fired6 = 0;
        fired16 = 0;
        for (int i = 0; i < 400; i++) begin
            if (!v6 || fired6) begin
                v6 = ($urandom_range(0, 3) != 0);
                a6 = 6'($urandom);
                b6 = ($urandom_range(0, 4) == 0) ? a6 : 6'($urandom);
                op6 = 3'($urandom);
                sg6 = 1'($urandom);
                cur6 = model(16'(a6), 16'(b6), op6, sg6, 6);
            end
            if (!v16 || fired16) begin
                v16 = ($urandom_range(0, 3) != 0);
                a16 = 16'($urandom);
                b16 = ($urandom_range(0, 4) == 0) ? a16 : 16'($urandom);
                op16 = 3'($urandom);
                sg16 = 1'($urandom);
                cur16 = model(a16, b16, op16, sg16, 16);
            end
            or6 = ($urandom_range(0, 3) != 0);
            or16 = ($urandom_range(0, 3) != 0);
            cyc();
        end
        v6 = 1'b0;
        v16 = 1'b0;
        or6 = 1'b1;
        or16 = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
